// File: rtl/ram_upload_streamer.sv
// Streams a window of main RAM to the HPS over the ioctl upload path.
// The HPS is stalled with ioctl_wait while each byte is fetched through the shared RAM read port.
module ram_upload_streamer #(
  parameter int ADDR_W  = 16,
  parameter int RAM_LAT = 2
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  output logic              ioctl_upload_req,
  input  logic              ioctl_upload,
  input  logic              ioctl_rd,
  input  logic [ADDR_W-1:0] ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_din,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_UP, ACTIVE, FETCH, DONE} state_t;

  localparam logic [2:0] LAT_LAST = 3'(RAM_LAT);

  state_t            state, state_next;
  logic [ADDR_W-1:0] win_addr, win_addr_next;
  logic [ADDR_W:0]   win_len, win_len_next;
  logic [2:0]        lat_cnt, lat_cnt_next;
  logic              ram_rd_next;
  logic [ADDR_W-1:0] ram_addr_next;
  logic              wait_next;
  logic [7:0]        din_next;

  assign ioctl_upload_req = (state == REQ);
  assign done             = (state == DONE);
  assign busy             = (state != IDLE);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      win_addr   <= '0;
      win_len    <= '0;
      lat_cnt    <= '0;
      ram_rd     <= 1'b0;
      ram_addr   <= '0;
      ioctl_wait <= 1'b0;
      ioctl_din  <= 8'h00;
    end else begin
      state      <= state_next;
      win_addr   <= win_addr_next;
      win_len    <= win_len_next;
      lat_cnt    <= lat_cnt_next;
      ram_rd     <= ram_rd_next;
      ram_addr   <= ram_addr_next;
      ioctl_wait <= wait_next;
      ioctl_din  <= din_next;
    end
  end

  always_comb begin
    state_next    = state;
    win_addr_next = win_addr;
    win_len_next  = win_len;
    lat_cnt_next  = lat_cnt;
    ram_rd_next   = 1'b0;
    ram_addr_next = ram_addr;
    wait_next     = ioctl_wait;
    din_next      = ioctl_din;
    case (state)
      IDLE: begin
        if (start) begin
          win_addr_next = start_addr;
          win_len_next  = length;
          state_next    = REQ;
        end
      end
      REQ:     state_next = WAIT_UP;
      WAIT_UP: if (ioctl_upload) state_next = ACTIVE;
      ACTIVE: begin
        if (!ioctl_upload) begin
          wait_next  = 1'b0;
          state_next = DONE;
        end else if (ioctl_rd) begin
          // Offsets past the window read back as zero without touching RAM.
          if ({1'b0, ioctl_addr} < win_len) begin
            ram_addr_next = win_addr + ioctl_addr;
            ram_rd_next   = 1'b1;
            wait_next     = 1'b1;
            lat_cnt_next  = '0;
            state_next    = FETCH;
          end else begin
            din_next = 8'h00;
          end
        end
      end
      FETCH: begin
        // lat_cnt reaches RAM_LAT exactly when ram_din carries the requested byte.
        if (!ioctl_upload) begin
          wait_next  = 1'b0;
          state_next = DONE;
        end else if (lat_cnt == LAT_LAST) begin
          din_next   = ram_din;
          wait_next  = 1'b0;
          state_next = ACTIVE;
        end else begin
          lat_cnt_next = lat_cnt + 3'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_upload_streamer.sv
// Randomised and directed bench for ram_upload_streamer against a RAM model with true read latency.
// Expected bytes come from the window rule: offset < length ? mem[start+offset] : 0.
module tb_ram_upload_streamer;

  localparam int ADDR_W  = 16;
  localparam int RAM_LAT = 2;

  logic              clk_sys = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W:0]   length = '0;
  logic              ioctl_upload_req;
  logic              ioctl_upload = 1'b0;
  logic              ioctl_rd = 1'b0;
  logic [ADDR_W-1:0] ioctl_addr = '0;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic              ram_rd;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_din;
  logic              busy;
  logic              done;

  int total = 0;
  int bad = 0;

  logic [7:0]  mem [0:65535];
  logic [8:0]  pipe [RAM_LAT];
  int          rd_count = 0;
  int          done_count = 0;
  int          req_count = 0;
  logic [15:0] last_ram_addr = '0;
  int          cur_sa = 0;
  int          cur_len = 0;

  ram_upload_streamer #(.ADDR_W(ADDR_W), .RAM_LAT(RAM_LAT)) dut (
    .clk_sys(clk_sys), .reset(reset), .start(start), .start_addr(start_addr), .length(length),
    .ioctl_upload_req(ioctl_upload_req), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .ram_rd(ram_rd),
    .ram_addr(ram_addr), .ram_din(ram_din), .busy(busy), .done(done)
  );

  always #5 clk_sys = ~clk_sys;

  // RAM with RAM_LAT cycles from sampled ram_rd to valid data; 5A marks "not valid yet".
  always @(posedge clk_sys) begin
    pipe[0] <= {ram_rd, mem[ram_addr]};
    for (int i = 1; i < RAM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_din = pipe[RAM_LAT-1][8] ? pipe[RAM_LAT-1][7:0] : 8'h5A;

  always @(posedge clk_sys) begin
    if (ram_rd) begin
      rd_count++;
      last_ram_addr = ram_addr;
    end
    if (done) done_count++;
    if (ioctl_upload_req) req_count++;
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int off);
    if (off < cur_len) return mem[16'((cur_sa + off) % 65536)];
    return 8'h00;
  endfunction

  task automatic begin_session(input int sa, input int len);
    int r0;
    r0 = req_count;
    cur_sa = sa;
    cur_len = len;
    start = 1'b1; start_addr = 16'(sa); length = 17'(len);
    tick();
    start = 1'b0;
    chk("req_pulse", {31'd0, ioctl_upload_req}, 32'd1);
    chk("busy_on", {31'd0, busy}, 32'd1);
    tick(); tick();
    chk("req_count", req_count - r0, 32'd1);
    ioctl_upload = 1'b1;
    tick(); tick();
    $display("session start sa=%04h len=%0d", sa, len);
  endtask

  task automatic end_session();
    int d0, n;
    d0 = done_count;
    ioctl_upload = 1'b0;
    n = 0;
    tick();
    while (busy === 1'b1 && n < 10) begin n++; tick(); end
    tick();
    chk("done_once", done_count - d0, 32'd1);
    chk("busy_off", {31'd0, busy}, 32'd0);
    $display("session end done_pulses=%0d busy=%0b", done_count - d0, busy);
  endtask

  task automatic do_read(input int off);
    int  rd0, n;
    bit  in_range;
    logic [7:0] e;
    rd0 = rd_count;
    in_range = (off < cur_len);
    e = exp_byte(off);
    ioctl_rd = 1'b1; ioctl_addr = 16'(off);
    tick();
    ioctl_rd = 1'b0;
    n = 0;
    while (ioctl_wait === 1'b1 && n < 20) begin n++; tick(); end
    chk("wait_cycles", n, in_range ? RAM_LAT + 1 : 0);
    chk("din", {24'd0, ioctl_din}, {24'd0, e});
    tick();
    chk("ram_rd_pulses", rd_count - rd0, in_range ? 1 : 0);
    if (in_range) chk("ram_addr", {16'd0, last_ram_addr}, (cur_sa + off) % 65536);
    $display("read off=%0h din=%02h exp=%02h wait=%0d", off, ioctl_din, e, n);
  endtask

  initial begin
    int d0, n;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom_range(0, 255));
      if (mem[i] == 8'h5A) mem[i] = 8'h5B;
    end
    mem[16'h4000] = 8'h11; mem[16'h4001] = 8'h22; mem[16'h4002] = 8'h33;

    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_out", {ioctl_upload_req, done, ioctl_wait, ram_rd, ioctl_din, ram_addr}, 32'd0);
    reset = 1'b0;
    tick();

    // Directed window, out-of-range read, ignored restart.
    begin_session(16'h4000, 3);
    for (int k = 0; k < 3; k++) do_read(k);
    do_read(5);
    start = 1'b1; start_addr = 16'h1234; length = 17'd100;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("restart_no_req", {31'd0, ioctl_upload_req}, 32'd0);
    do_read(0);
    do_read(3);
    end_session();

    // Address wrap.
    begin_session(16'hFFFE, 4);
    for (int k = 0; k < 4; k++) do_read(k);
    end_session();

    // Random windows, including the full 64K window.
    for (int s = 0; s < 3; s++) begin
      int len;
      len = (s == 2) ? 65536 : $urandom_range(1, 300);
      begin_session($urandom_range(0, 65535), len);
      for (int k = 0; k < 8; k++) do_read((s == 2) ? $urandom_range(0, 65535) : $urandom_range(0, len + 20));
      if (s == 2) do_read(65535);
      end_session();
    end

    // Zero-length window still handshakes.
    begin_session(16'h0100, 0);
    do_read(0);
    end_session();

    // Upload dropped during fetch.
    begin_session(16'h2000, 8);
    d0 = done_count;
    ioctl_rd = 1'b1; ioctl_addr = 16'd2;
    tick();
    ioctl_rd = 1'b0;
    tick();
    ioctl_upload = 1'b0;
    tick();
    chk("drop_wait", {31'd0, ioctl_wait}, 32'd0);
    n = 0;
    while (busy === 1'b1 && n < 10) begin n++; tick(); end
    tick(); tick();
    chk("drop_done", done_count - d0, 32'd1);
    chk("drop_busy", {31'd0, busy}, 32'd0);
    $display("drop during fetch done_pulses=%0d", done_count - d0);

    // Reset in fetch.
    begin_session(16'h3000, 8);
    d0 = done_count;
    ioctl_rd = 1'b1; ioctl_addr = 16'd1;
    tick();
    ioctl_rd = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_out", {ioctl_upload_req, done, ioctl_wait, ram_rd, busy, ioctl_din, ram_addr}, 32'd0);
    ioctl_upload = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    chk("rst_no_done", done_count - d0, 32'd0);
    $display("reset during fetch done_pulses=%0d", done_count - d0);
    begin_session(16'h3000, 8);
    do_read(4);
    end_session();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
